// File: rtl/dmem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_stage
//  Purpose  : Memory-access / writeback-select stage. Accepts one executed
//             instruction per handshake, performs byte/half/word loads and
//             stores on an internal byte-addressed memory, and presents the
//             register-file writeback triple. Bad accesses are suppressed
//             and flagged on misalign_o.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_stage #(
  parameter int          AWIDTH    = 32,
  parameter int          DWIDTH    = 32,
  parameter int          MEM_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2data_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [1:0]        wbsel_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [4:0]        wb_rd_o,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic              wb_regwren_o,
  output logic              misalign_o
);

  localparam int IW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              regwren_q, regwren_d;
  logic              misal_q, misal_d;
  logic [IW-3:0]     ld_widx_q, ld_widx_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [2:0]        ld_f3_q, ld_f3_d;

  logic [7:0]        mem_q [MEM_BYTES];

  logic              w_ready, w_accept;
  logic [AWIDTH-1:0] w_off;
  logic [IW-1:0]     w_idx;
  logic              w_is_load, w_is_store, w_both, w_misal, w_ld_legal, w_st_legal;
  logic              w_bad, w_st_ok;
  logic [3:0]        w_be;
  logic [DWIDTH-1:0] w_wdata;
  logic [DWIDTH-1:0] w_rword, w_rsh, w_ld_fmt;
  logic              w_unused_bits;

  assign w_ready  = (state_q == S_IDLE) | ((state_q == S_RESP) & wb_ready_i);
  assign w_accept = req_valid_i & w_ready;

  // Address decode: offset from the base, wrapped into the memory size
  assign w_off         = AWIDTH'(alu_res_i) - BASE_ADDR;
  assign w_idx         = w_off[IW-1:0];
  assign w_unused_bits = ^w_off[AWIDTH-1:IW];

  assign w_is_load  = memren_i & ~memwren_i;
  assign w_is_store = memwren_i & ~memren_i;
  assign w_both     = memren_i & memwren_i;
  assign w_misal    = ((funct3_i[1:0] == 2'b01) & w_idx[0]) |
                      ((funct3_i[1:0] == 2'b10) & (w_idx[1:0] != 2'b00));
  assign w_ld_legal = (funct3_i == 3'd0) | (funct3_i == 3'd1) | (funct3_i == 3'd2) |
                      (funct3_i == 3'd4) | (funct3_i == 3'd5);
  assign w_st_legal = (funct3_i == 3'd0) | (funct3_i == 3'd1) | (funct3_i == 3'd2);
  assign w_bad      = w_both | (w_is_load & (~w_ld_legal | w_misal)) |
                      (w_is_store & (~w_st_legal | w_misal));
  assign w_st_ok    = w_is_store & ~w_bad;

  // Store lane enables and data, shifted into the addressed byte lanes
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   w_be = 4'b0001 << w_idx[1:0];
      2'b01:   w_be = 4'b0011 << w_idx[1:0];
      default: w_be = 4'b1111;
    endcase
    w_wdata = rs2data_i << {w_idx[1:0], 3'b000};
  end

  // Load word fetch and sign/zero formatting from the latched request
  always_comb begin
    w_rword = {mem_q[{ld_widx_q, 2'd3}], mem_q[{ld_widx_q, 2'd2}],
               mem_q[{ld_widx_q, 2'd1}], mem_q[{ld_widx_q, 2'd0}]};
    w_rsh   = w_rword >> {ld_off_q, 3'b000};
    case (ld_f3_q)
      3'd0:    w_ld_fmt = {{24{w_rsh[7]}}, w_rsh[7:0]};
      3'd1:    w_ld_fmt = {{16{w_rsh[15]}}, w_rsh[15:0]};
      3'd2:    w_ld_fmt = w_rsh;
      3'd4:    w_ld_fmt = {24'd0, w_rsh[7:0]};
      3'd5:    w_ld_fmt = {16'd0, w_rsh[15:0]};
      default: w_ld_fmt = '0;
    endcase
  end

  // Next-state and response-register logic
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    data_d    = data_q;
    regwren_d = regwren_q;
    misal_d   = misal_q;
    ld_widx_d = ld_widx_q;
    ld_off_d  = ld_off_q;
    ld_f3_d   = ld_f3_q;

    case (state_q)
      S_LOAD: begin
        data_d  = w_ld_fmt;
        state_d = S_RESP;
      end
      S_RESP: if (wb_ready_i) state_d = S_IDLE;
      default: state_d = state_q;
    endcase

    // A new request overrides the drain path above (RESP accepts only when consumed)
    if (w_accept) begin
      rd_d      = rd_i;
      data_d    = '0;
      regwren_d = 1'b0;
      misal_d   = 1'b0;
      if (w_bad) begin
        misal_d = 1'b1;
        state_d = S_RESP;
      end else if (w_is_load) begin
        ld_widx_d = w_idx[IW-1:2];
        ld_off_d  = w_idx[1:0];
        ld_f3_d   = funct3_i;
        regwren_d = regwren_i & (rd_i != 5'd0);
        state_d   = S_LOAD;
      end else if (w_is_store) begin
        state_d = S_RESP;
      end else begin
        case (wbsel_i)
          2'd0:    data_d = alu_res_i;
          2'd2:    data_d = DWIDTH'(pc_i + AWIDTH'(4));
          default: data_d = '0;
        endcase
        regwren_d = regwren_i & (rd_i != 5'd0);
        state_d   = S_RESP;
      end
    end
  end

  // State and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      data_q    <= '0;
      regwren_q <= 1'b0;
      misal_q   <= 1'b0;
      ld_widx_q <= '0;
      ld_off_q  <= '0;
      ld_f3_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      regwren_q <= regwren_d;
      misal_q   <= misal_d;
      ld_widx_q <= ld_widx_d;
      ld_off_q  <= ld_off_d;
      ld_f3_q   <= ld_f3_d;
    end
  end

  // Store commit on the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && w_accept && w_st_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[{w_idx[IW-1:2], 2'(b)}] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready_o  = w_ready;
  assign wb_valid_o   = (state_q == S_RESP);
  assign wb_rd_o      = rd_q;
  assign wb_data_o    = data_q;
  assign wb_regwren_o = regwren_q;
  assign misalign_o   = misal_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_stage
//  Purpose  : Directed self-checking bench for dmem_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] pc_i, alu_res_i, rs2data_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        regwren_i, memren_i, memwren_i;
  logic [1:0]  wbsel_i;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_regwren_o, misalign_o;

  int total = 0;
  int bad   = 0;

  dmem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .pc_i         (pc_i),
    .alu_res_i    (alu_res_i),
    .rs2data_i    (rs2data_i),
    .funct3_i     (funct3_i),
    .rd_i         (rd_i),
    .regwren_i    (regwren_i),
    .memren_i     (memren_i),
    .memwren_i    (memwren_i),
    .wbsel_i      (wbsel_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .wb_regwren_o (wb_regwren_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [2:0] f3, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic [1:0] ws);
    pc_i = pc; alu_res_i = alu; rs2data_i = rs2; funct3_i = f3; rd_i = rd;
    regwren_i = rw; memren_i = mr; memwren_i = mw; wbsel_i = ws;
    req_valid_i = 1'b1;
  endtask

  // Store from IDLE: response next cycle with no register write, then drain
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] data);
    drive(32'h0, addr, data, f3, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0);
    step();
    req_valid_i = 1'b0;
    check({tag, "_valid"}, {31'd0, wb_valid_o}, 32'd1);
    check({tag, "_rwen"}, {31'd0, wb_regwren_o}, 32'd0);
    check({tag, "_mis"}, {31'd0, misalign_o}, 32'd0);
    step();
  endtask

  // Load from IDLE: not valid after accept, valid with data one cycle later
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] exp);
    drive(32'h0, addr, 32'h0, f3, 5'd10, 1'b1, 1'b1, 1'b0, 2'd1);
    step();
    req_valid_i = 1'b0;
    check({tag, "_lat"}, {31'd0, wb_valid_o}, 32'd0);
    step();
    check({tag, "_valid"}, {31'd0, wb_valid_o}, 32'd1);
    check({tag, "_data"}, wb_data_o, exp);
    check({tag, "_rwen"}, {31'd0, wb_regwren_o}, 32'd1);
    check({tag, "_mis"}, {31'd0, misalign_o}, 32'd0);
    step();
  endtask

  // Any request that must be rejected as a bad access
  task automatic do_bad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                        input logic mr, input logic mw);
    drive(32'h0, addr, 32'h0000_AAAA, f3, 5'd3, 1'b1, mr, mw, 2'd1);
    step();
    req_valid_i = 1'b0;
    check({tag, "_valid"}, {31'd0, wb_valid_o}, 32'd1);
    check({tag, "_mis"}, {31'd0, misalign_o}, 32'd1);
    check({tag, "_rwen"}, {31'd0, wb_regwren_o}, 32'd0);
    check({tag, "_data"}, wb_data_o, 32'd0);
    step();
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; wb_ready_i = 1'b1;
    pc_i = '0; alu_res_i = '0; rs2data_i = '0; funct3_i = '0; rd_i = '0;
    regwren_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0; wbsel_i = '0;

    // Reset and idle
    step(); step();
    rst = 1'b0;
    step();
    check("rst_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_rd", {27'd0, wb_rd_o}, 32'd0);
    check("rst_data", wb_data_o, 32'd0);
    check("rst_rwen", {31'd0, wb_regwren_o}, 32'd0);
    check("rst_mis", {31'd0, misalign_o}, 32'd0);
    step();
    check("idle_valid", {31'd0, wb_valid_o}, 32'd0);

    // Store word then loads of each size/sign
    do_store("sw10", 32'h0100_0010, 3'd2, 32'hDEAD_BEEF);
    do_load("lb13", 32'h0100_0013, 3'd0, 32'hFFFF_FFDE);
    do_load("lbu13", 32'h0100_0013, 3'd4, 32'h0000_00DE);
    do_load("lh12", 32'h0100_0012, 3'd1, 32'hFFFF_DEAD);
    do_load("lw10", 32'h0100_0010, 3'd2, 32'hDEAD_BEEF);
    do_load("lhu10", 32'h0100_0010, 3'd5, 32'h0000_BEEF);
    do_load("lb11", 32'h0100_0011, 3'd0, 32'hFFFF_FFBE);
    do_load("lwwrap", 32'h0100_1010, 3'd2, 32'hDEAD_BEEF);

    // ALU then JAL back to back with consumer always ready
    drive(32'h0, 32'h0000_1234, 32'h0, 3'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0);
    step();
    drive(32'h0100_0000, 32'h0, 32'h0, 3'd0, 5'd1, 1'b1, 1'b0, 1'b0, 2'd2);
    check("alu_valid", {31'd0, wb_valid_o}, 32'd1);
    check("alu_data", wb_data_o, 32'h0000_1234);
    check("alu_rd", {27'd0, wb_rd_o}, 32'd5);
    check("alu_ready", {31'd0, req_ready_o}, 32'd1);
    step();
    req_valid_i = 1'b0;
    check("jal_valid", {31'd0, wb_valid_o}, 32'd1);
    check("jal_data", wb_data_o, 32'h0100_0004);
    check("jal_rwen", {31'd0, wb_regwren_o}, 32'd1);
    check("jal_rd", {27'd0, wb_rd_o}, 32'd1);
    step();
    check("jal_drain", {31'd0, wb_valid_o}, 32'd0);

    // rd=0 suppresses write; reserved wbsel yields zero
    drive(32'h0, 32'h0000_0077, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    step();
    req_valid_i = 1'b0;
    check("rd0_rwen", {31'd0, wb_regwren_o}, 32'd0);
    check("rd0_data", wb_data_o, 32'h0000_0077);
    step();
    drive(32'h0, 32'h0000_0077, 32'h0, 3'd0, 5'd4, 1'b1, 1'b0, 1'b0, 2'd3);
    step();
    req_valid_i = 1'b0;
    check("ws3_data", wb_data_o, 32'd0);
    check("ws3_rwen", {31'd0, wb_regwren_o}, 32'd1);
    step();

    // Misaligned / illegal accesses leave memory untouched
    do_store("sw20", 32'h0100_0020, 3'd2, 32'h1122_3344);
    do_bad("sh21", 32'h0100_0021, 3'd1, 1'b0, 1'b1);
    do_load("lw20", 32'h0100_0020, 3'd2, 32'h1122_3344);
    do_bad("lw22", 32'h0100_0022, 3'd2, 1'b1, 1'b0);
    do_bad("ldf3", 32'h0100_0020, 3'd3, 1'b1, 1'b0);
    do_bad("stf4", 32'h0100_0020, 3'd4, 1'b0, 1'b1);
    do_bad("both", 32'h0100_0020, 3'd2, 1'b1, 1'b1);
    do_load("lw20b", 32'h0100_0020, 3'd2, 32'h1122_3344);

    // Store immediately followed by a load to the same byte
    drive(32'h0, 32'h0100_0030, 32'h0000_007F, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0);
    step();
    drive(32'h0, 32'h0100_0030, 32'h0, 3'd4, 5'd9, 1'b1, 1'b1, 1'b0, 2'd1);
    step();
    req_valid_i = 1'b0;
    step();
    check("sbl_valid", {31'd0, wb_valid_o}, 32'd1);
    check("sbl_data", wb_data_o, 32'h0000_007F);
    step();

    // Backpressure: response frozen, no accept while consumer stalls
    wb_ready_i = 1'b0;
    drive(32'h0, 32'h0000_5555, 32'h0, 3'd0, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0);
    step();
    drive(32'h0, 32'h0000_6666, 32'h0, 3'd0, 5'd8, 1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, wb_valid_o}, 32'd1);
      check("bp_data", wb_data_o, 32'h0000_5555);
      check("bp_rd", {27'd0, wb_rd_o}, 32'd7);
      check("bp_ready", {31'd0, req_ready_o}, 32'd0);
      step();
    end
    wb_ready_i = 1'b1;
    #1;
    check("bp_release", {31'd0, req_ready_o}, 32'd1);
    step();
    req_valid_i = 1'b0;
    check("bp_next_data", wb_data_o, 32'h0000_6666);
    check("bp_next_rd", {27'd0, wb_rd_o}, 32'd8);
    step();
    check("bp_drain", {31'd0, wb_valid_o}, 32'd0);

    // Reset while a load is in flight
    drive(32'h0, 32'h0100_0010, 32'h0, 3'd2, 5'd10, 1'b1, 1'b1, 1'b0, 2'd1);
    step();
    req_valid_i = 1'b0;
    check("rl_inload", {31'd0, wb_valid_o}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rl_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rl_ready", {31'd0, req_ready_o}, 32'd1);
    step();
    check("rl_noresp", {31'd0, wb_valid_o}, 32'd0);
    do_load("rl_mem", 32'h0100_0010, 3'd2, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_stage.md
# dmem_stage

Memory-access and writeback-select stage placed directly downstream of the execute stage. It accepts one executed instruction per handshake (ALU result, store data, control bits), performs byte/half/word loads and stores against an internal byte-addressed data memory, and presents the register-file writeback triple (rd, data, enable). Loads add one cycle of synchronous-read latency. Misaligned or illegal accesses are suppressed and flagged.

## Interface
- AWIDTH, 32, address/PC width
- DWIDTH, 32, data width (fixed at 32 for load/store formatting)
- MEM_BYTES, 4096, data memory size in bytes; power of two
- BASE_ADDR, 32'h0100_0000, byte address mapped to memory index 0

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  execute result valid
- req_ready_o  out  1  stage can accept a request this cycle
- pc_i  in  AWIDTH  instruction PC
- alu_res_i  in  DWIDTH  ALU result / effective address
- rs2data_i  in  DWIDTH  store data
- funct3_i  in  3  access size/sign (RV32I load/store encoding)
- rd_i  in  5  destination register
- regwren_i  in  1  instruction writes rd
- memren_i  in  1  load
- memwren_i  in  1  store
- wbsel_i  in  2  0 ALU, 1 memory, 2 PC+4, 3 reserved (gives 0)
- wb_valid_o  out  1  writeback result valid
- wb_ready_i  in  1  consumer takes result
- wb_rd_o  out  5  destination register
- wb_data_o  out  DWIDTH  writeback data
- wb_regwren_o  out  1  register write enable
- misalign_o  out  1  response carries a misaligned/illegal access

## Operation
- States: IDLE, LOAD, RESP.
- req_ready_o = (state==IDLE) | (state==RESP & wb_ready_i).
- Accept = req_valid_i & req_ready_o; request fields latched on the accept edge.
- Memory index = (alu_res_i - BASE_ADDR) mod MEM_BYTES (low log2(MEM_BYTES) bits); out-of-range addresses wrap, no error.
- Alignment: half (funct3[1:0]=01) needs addr[0]=0; word (10) needs addr[1:0]=0. Load funct3 legal: 0,1,2,4,5. Store funct3 legal: 0,1,2. memren_i & memwren_i both set is illegal.
- Bad access: no memory write, response with wb_regwren_o=0, wb_data_o=0, misalign_o=1.
- Store (legal): bytes written on the accept edge (SB 1, SH 2, SW 4 bytes, little-endian, from rs2data_i LSBs); next state RESP, wb_regwren_o=0.
- Load (legal): next state LOAD; the LOAD-cycle edge reads 4 bytes at the word-aligned index; next state RESP; data shifted by addr[1:0], LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
- Non-memory: next state RESP; wb_data_o = ALU result, PC+4 (mod 2^AWIDTH) or 0 per wbsel_i; wb_regwren_o = regwren_i.
- wb_regwren_o forced 0 when rd=0.
- RESP: wb_valid_o=1, outputs stable until wb_ready_i. On wb_ready_i: accept next request if present (go LOAD/RESP per its type), else IDLE.
- Memory contents are not cleared by rst.

## Timing
- Reset: state IDLE, wb_valid_o=0, wb_rd_o=0, wb_data_o=0, wb_regwren_o=0, misalign_o=0, req_ready_o=1 the cycle after rst deasserts.
- Accept at edge N: non-load/store wb_valid_o=1 in cycle N+1; load wb_valid_o=1 in cycle N+2.
- Peak throughput one non-load per cycle (back-to-back via RESP & wb_ready_i); loads one per 2 cycles.
- Store followed by load to same address: load reads in a later cycle than the store write, so it returns the new data.
- rst during LOAD/RESP: pending response discarded, state IDLE next cycle; stores already committed stay in memory.
- wb_ready_i low in RESP: req_ready_o=0, no new accept, outputs frozen.

## Test plan
- Reset then idle: rst 2 cycles -> all outputs 0, req_ready_o=1, wb_valid_o stays 0 with req_valid_i=0.
- SW 0xDEADBEEF at 0x0100_0010, then LB/LBU at 0x0100_0013, LH at 0x0100_0012, LW at 0x0100_0010 -> 0xFFFF_FFDE, 0x0000_00DE, 0xFFFF_DEAD, 0xDEADBEEF; each load response 2 cycles after accept.
- ALU op wbsel=0 res 0x1234, then JAL wbsel=2 pc 0x0100_0000 rd=1, wb_ready_i held 1 -> consecutive cycles give 0x1234, then 0x0100_0004 with wb_regwren_o=1.
- SH at 0x0100_0021 data 0xAAAA -> misalign_o=1, wb_regwren_o=0; subsequent LW at 0x0100_0020 returns previous contents unchanged.
- Backpressure: wb_ready_i=0 for 3 cycles during RESP -> wb_* stable, req_ready_o=0; on release one handshake, then next request accepted.
- rst asserted in LOAD state -> next cycle IDLE, wb_valid_o=0, no response for the aborted load.
